// File: rtl/idma_data_rgba2rgb_256b.sv
// idma_data_rgba2rgb_256b: strips the alpha byte from 8x32b RGBA pixels per 256b beat and
// packs the 24b RGB pixels densely, so four input beats become three output beats.
// Latency: an accepted beat appears on b_data_out the next cycle. A partial final group is
// flushed zero-padded in one extra cycle.
// Backpressure: the output register holds while b_valid_out && !b_ready_in, and f_ready_out is
// low in that case and during the flush cycle.
// Optional: define IDMA_RGBA2RGB_STRB_EN to add the registered byte strobe output b_strb.

module idma_data_rgba2rgb_256b (
  input  logic         clk,
  input  logic         rst,
  input  logic         f_valid_in,
  input  logic [255:0] f_data_in,
  input  logic         f_data_last,
  output logic         f_ready_out,
  output logic         b_valid_out,
  output logic [255:0] b_data_out,
  output logic         b_data_last,
  input  logic         b_ready_in
`ifdef IDMA_RGBA2RGB_STRB_EN
  ,
  output logic [31:0]  b_strb
`endif
);

  // Phase within the 4-in/3-out packing cycle; FLUSH drains a partial group.
  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    FLUSH = 3'd4
  } state_t;

  // Flush length codes: the number of residual bits still held when the frame ended.
  localparam logic [1:0] FLEN_192 = 2'd0;
  localparam logic [1:0] FLEN_128 = 2'd1;
  localparam logic [1:0] FLEN_64  = 2'd2;

  state_t         r_state;
  logic [191:0]   r_res;
  logic [1:0]     r_flen;
  logic           r_b_valid;
  logic [255:0]   r_b_dat;
  logic           r_b_last;
  logic [31:0]    r_b_strb;

  logic [191:0]   w_chunk;
  logic           w_free;
  logic           w_hs;
  logic [255:0]   w_flush_dat;
  logic [31:0]    w_flush_strb;

  // Drop the alpha byte of each pixel and close the gaps: 8 x 24b = 192b chunk.
  always_comb begin
    w_chunk = '0;
    for (int i = 0; i < 8; i++) begin
      w_chunk[24*i +: 24] = f_data_in[32*i +: 24];
    end
  end

  // The output slot can take a new beat when empty or being drained this cycle.
  assign w_free      = !r_b_valid || b_ready_in;
  assign f_ready_out = w_free && (r_state != FLUSH);
  assign w_hs        = f_valid_in && f_ready_out;

  // Flush beat contents: only the residual bits that are still valid, upper bits zero.
  always_comb begin
    w_flush_dat  = '0;
    w_flush_strb = '0;
    case (r_flen)
      FLEN_192: begin
        w_flush_dat  = {64'b0, r_res};
        w_flush_strb = 32'h00FF_FFFF;
      end
      FLEN_128: begin
        w_flush_dat  = {128'b0, r_res[127:0]};
        w_flush_strb = 32'h0000_FFFF;
      end
      FLEN_64: begin
        w_flush_dat  = {192'b0, r_res[63:0]};
        w_flush_strb = 32'h0000_00FF;
      end
      default: begin
        w_flush_dat  = '0;
        w_flush_strb = '0;
      end
    endcase
  end

  // Packing FSM with the residual register and the registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S0;
      r_res     <= '0;
      r_flen    <= FLEN_192;
      r_b_valid <= 1'b0;
      r_b_dat   <= '0;
      r_b_last  <= 1'b0;
      r_b_strb  <= '0;
    end else begin
      // A consumed beat empties the slot unless a new beat is loaded below.
      if (r_b_valid && b_ready_in) begin
        r_b_valid <= 1'b0;
      end
      case (r_state)
        S0: begin
          // First beat of a group only fills the residual; nothing to emit yet.
          if (w_hs) begin
            r_res   <= w_chunk;
            r_flen  <= FLEN_192;
            r_state <= f_data_last ? FLUSH : S1;
          end
        end
        S1: begin
          // 192 residual bits + low 64 chunk bits; 128 bits carry over.
          if (w_hs) begin
            r_b_valid <= 1'b1;
            r_b_dat   <= {w_chunk[63:0], r_res};
            r_b_last  <= 1'b0;
            r_b_strb  <= '1;
            r_res     <= {64'b0, w_chunk[191:64]};
            r_flen    <= FLEN_128;
            r_state   <= f_data_last ? FLUSH : S2;
          end
        end
        S2: begin
          // 128 residual bits + low 128 chunk bits; 64 bits carry over.
          if (w_hs) begin
            r_b_valid <= 1'b1;
            r_b_dat   <= {w_chunk[127:0], r_res[127:0]};
            r_b_last  <= 1'b0;
            r_b_strb  <= '1;
            r_res     <= {128'b0, w_chunk[191:128]};
            r_flen    <= FLEN_64;
            r_state   <= f_data_last ? FLUSH : S3;
          end
        end
        S3: begin
          // 64 residual bits + the whole chunk close the group exactly; no flush needed.
          if (w_hs) begin
            r_b_valid <= 1'b1;
            r_b_dat   <= {w_chunk, r_res[63:0]};
            r_b_last  <= f_data_last;
            r_b_strb  <= '1;
            r_res     <= '0;
            r_state   <= S0;
          end
        end
        FLUSH: begin
          // Emit the leftover residual as the last beat of the frame.
          if (w_free) begin
            r_b_valid <= 1'b1;
            r_b_dat   <= w_flush_dat;
            r_b_last  <= 1'b1;
            r_b_strb  <= w_flush_strb;
            r_res     <= '0;
            r_state   <= S0;
          end
        end
        default: begin
          r_state <= S0;
        end
      endcase
    end
  end

  assign b_valid_out = r_b_valid;
  assign b_data_out  = r_b_dat;
  assign b_data_last = r_b_last;

`ifdef IDMA_RGBA2RGB_STRB_EN
  assign b_strb = r_b_strb;
`else
  // Strobe register is unused without the strobe port; synthesis removes it.
  logic w_strb_unused;
  assign w_strb_unused = ^r_b_strb;
`endif

endmodule

// File: tb/tb_idma_data_rgba2rgb_256b.sv
module tb_idma_data_rgba2rgb_256b;

  logic         clk = 1'b0;
  logic         rst;
  logic         f_valid_in;
  logic [255:0] f_data_in;
  logic         f_data_last;
  wire          f_ready_out;
  wire          b_valid_out;
  wire  [255:0] b_data_out;
  wire          b_data_last;
  wire          b_ready_in;
`ifdef IDMA_RGBA2RGB_STRB_EN
  wire  [31:0]  b_strb;
`endif

  logic rdy_fix = 1'b1;
  logic tgl_en  = 1'b0;
  logic r_tgl   = 1'b1;
  assign b_ready_in = tgl_en ? r_tgl : rdy_fix;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  typedef struct packed {
    logic [255:0] d;
    logic         l;
    logic [31:0]  s;
  } beat_t;
  beat_t oq[$];

  // Reference model: RGB bytes of all sent beats laid end to end, zero beyond.
  logic [1535:0] m_stream;
  int            m_nin;

  logic         prev_stall = 1'b0;
  logic [255:0] prev_d;
  logic         prev_l;

  idma_data_rgba2rgb_256b dut (
    .clk         (clk),
    .rst         (rst),
    .f_valid_in  (f_valid_in),
    .f_data_in   (f_data_in),
    .f_data_last (f_data_last),
    .f_ready_out (f_ready_out),
    .b_valid_out (b_valid_out),
    .b_data_out  (b_data_out),
    .b_data_last (b_data_last),
    .b_ready_in  (b_ready_in)
`ifdef IDMA_RGBA2RGB_STRB_EN
    ,
    .b_strb      (b_strb)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    r_tgl = ~r_tgl;
  end

  // Output monitor: records every handshaked beat and checks stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert (b_data_out === prev_d && b_data_last === prev_l && b_valid_out === 1'b1)
        else begin
          errors++;
          $error("FAIL stall_hold: got last=%b data=%h want last=%b data=%h", b_data_last, b_data_out, prev_l, prev_d);
        end
      end
      if (b_valid_out && b_ready_in) begin
        beat_t b;
        b.d = b_data_out;
        b.l = b_data_last;
        b.s = '0;
`ifdef IDMA_RGBA2RGB_STRB_EN
        b.s = b_strb;
`endif
        oq.push_back(b);
      end
      prev_stall = b_valid_out && !b_ready_in;
      prev_d     = b_data_out;
      prev_l     = b_data_last;
    end
  end

  function automatic logic [255:0] mk(input int base, input logic [7:0] a);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = {a, 24'(base + i)};
    return r;
  endfunction

  task automatic model_clear();
    m_stream = '0;
    m_nin    = 0;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, append it to the model.
  task automatic send(input logic [255:0] d, input logic l);
    int w;
    w = 0;
    f_valid_in  = 1'b1;
    f_data_in   = d;
    f_data_last = l;
    while (w < 100) begin
      @(negedge clk);
      if (b_valid_out && !b_ready_in) chk("no_accept_when_stalled", {255'b0, f_ready_out}, 256'd0);
      if (f_ready_out) break;
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 100) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: got no acceptance want acceptance within 100 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
    stall_cnt += w;
    for (int i = 0; i < 8; i++) m_stream[192*m_nin + 24*i +: 24] = d[32*i +: 24];
    m_nin++;
    f_valid_in  = 1'b0;
    f_data_last = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (oq.size() < n && k < 60) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("out_count", 256'(oq.size()), 256'(n));
  endtask

  // Compare queued beats against the model; la/lb are the beat indices expected to carry last.
  task automatic check_out(input int nout, input int la, input int lb, input int tot_bytes);
    beat_t b;
    int    bytes;
    logic [31:0] es;
    for (int j = 0; j < nout; j++) begin
      if (oq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL beat_missing: got no beat %0d want a beat", j);
      end else begin
        b = oq.pop_front();
        chk("beat_data", b.d, m_stream[256*j +: 256]);
        chk("beat_last", {255'b0, b.l}, {255'b0, ((j == la) || (j == lb))});
        bytes = tot_bytes - 32*j;
        es = (bytes >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bytes) - 32'd1);
`ifdef IDMA_RGBA2RGB_STRB_EN
        chk("beat_strb", {224'b0, b.s}, {224'b0, es});
`else
        if (es == 32'd0) $display("note: empty strobe for beat %0d", j);
`endif
      end
    end
  endtask

  initial begin
    beat_t        p;
    logic [255:0] d3;
    rst         = 1'b1;
    f_valid_in  = 1'b0;
    f_data_in   = '0;
    f_data_last = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_valid", {255'b0, b_valid_out}, 256'd0);
    chk("rst_data", b_data_out, 256'd0);
    chk("rst_last", {255'b0, b_data_last}, 256'd0);
    chk("rst_ready", {255'b0, f_ready_out}, 256'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: four beats, pixel k = {FF, k}, last on beat 3 (index 3)
    model_clear();
    for (int b = 0; b < 4; b++) send(mk(8*b, 8'hFF), b == 3);
    wait_out(3);
    p = oq[0];
    for (int i = 0; i < 10; i++) chk("t1_beat0_px", {232'b0, p.d[24*i +: 24]}, 256'(i));
    chk("t1_beat0_top", {240'b0, p.d[240 +: 16]}, 256'h000A);
    p = oq[2];
    chk("t1_beat2_top", {232'b0, p.d[232 +: 24]}, 256'h00001F);
    check_out(3, 2, -1, 96);

    // 2: same stream with ready toggling every cycle
    model_clear();
    tgl_en = 1'b1;
    for (int b = 0; b < 4; b++) send(mk(8*b, 8'hFF), b == 3);
    wait_out(3);
    check_out(3, 2, -1, 96);
    tgl_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 3: single beat with last -> one 192b flush beat
    model_clear();
    d3 = '0;
    for (int i = 0; i < 8; i++) d3[32*i +: 32] = {8'hAA, 24'h111111 * 24'(i + 1)};
    send(d3, 1'b1);
    chk("t3_flush_notready", {255'b0, f_ready_out}, 256'd0);
    wait_out(1);
    p = oq[0];
    chk("t3_low192", {64'b0, p.d[191:0]}, {64'b0, 192'h888888_777777_666666_555555_444444_333333_222222_111111});
    chk("t3_high64", {192'b0, p.d[255:192]}, 256'd0);
    check_out(1, 0, -1, 24);

    // 4: three-beat frame -> two full beats then a 64b flush
    model_clear();
    for (int b = 0; b < 3; b++) send(mk(100 + 8*b, 8'h55), b == 2);
    chk("t4_flush_notready", {255'b0, f_ready_out}, 256'd0);
    @(posedge clk);
    #1;
    chk("t4_ready_after_flush", {255'b0, f_ready_out}, 256'd1);
    wait_out(3);
    check_out(3, 2, -1, 72);

    // 5: two four-beat frames back to back, no input stalls
    model_clear();
    stall_cnt = 0;
    for (int b = 0; b < 8; b++) send(mk(8*b + 32, 8'hC3), (b == 3) || (b == 7));
    chk("t5_no_stalls", 256'(stall_cnt), 256'd0);
    wait_out(6);
    check_out(6, 2, 5, 192);

    // 6: reset after two accepted beats, then a clean frame
    model_clear();
    send(mk(200, 8'h11), 1'b0);
    send(mk(208, 8'h22), 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {255'b0, b_valid_out}, 256'd0);
    chk("t6_rst_data", b_data_out, 256'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    oq.delete();
    @(posedge clk);
    #1;
    model_clear();
    for (int b = 0; b < 4; b++) send(mk(8*b, 8'hFF), b == 3);
    wait_out(3);
    p = oq[0];
    chk("t6_beat0_top", {240'b0, p.d[240 +: 16]}, 256'h000A);
    check_out(3, 2, -1, 96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idma_data_rgba2rgb_256b.md
Name: idma_data_rgba2rgb_256b

Overview:
Write-side companion to the iDMA RGB-to-RGBA expander. Takes a 256b stream of 32b RGBA pixels (8 per beat), strips the alpha byte (bits [31:24] of each pixel), and packs the 24b RGB pixels densely into 256b output beats. Four input beats become three output beats. Sits in idma_data_noc between the internal data path and the NoC/AXI write side. A partial final group is flushed zero-padded.

Parameters:
None. Widths are fixed: 256b data, 32b in-pixel, 24b out-pixel.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
f_valid_in  input  1  input beat valid
f_data_in  input  256  8 RGBA pixels; pixel i at [32i+:32], alpha at [32i+24+:8]
f_data_last  input  1  last input beat of frame; qualified by f_valid_in
f_ready_out  output  1  input beat accepted when f_valid_in && f_ready_out
b_valid_out  output  1  output beat valid (registered)
b_data_out  output  256  packed RGB stream (registered)
b_data_last  output  1  last output beat of frame (registered)
b_ready_in  input  1  downstream ready

Behaviour:
- Chunk c[191:0] of an accepted beat: c[24i+:24] = f_data_in[32i+:24], i=0..7; alpha discarded.
- Residual register res[191:0]; phase FSM states S0, S1, S2, S3, FLUSH; f_hs = f_valid_in && f_ready_out.
- Output register slot: free = !b_valid_out || b_ready_in. b_valid_out is set when a beat is loaded; it is cleared on b_ready_in when nothing is loaded.
- f_ready_out = free && (state != FLUSH). This is combinational and has no dependency on f_valid_in.
- S0, on f_hs: res <= c, no output load. Next state is FLUSH if f_data_last, else S1.
- S1, on f_hs: load out {c[63:0], res[191:0]}, last=0. res[127:0] <= c[191:64]. Next state is FLUSH if f_data_last, else S2.
- S2, on f_hs: load out {c[127:0], res[127:0]}, last=0. res[63:0] <= c[191:128]. Next state is FLUSH if f_data_last, else S3.
- S3, on f_hs: load out {c[191:0], res[63:0]}, last=f_data_last. Next state is S0.
- FLUSH, when free: load out {zeros, res valid bits}, last=1. Valid bits are 192 (entered from S0), 128 (from S1) or 64 (from S2); unused upper bits are 0. Next state is S0.
- A 2-bit flush-length register records the entry phase.
- Latency: an accepted beat appears on b_data_out the next cycle. Throughput: 3 out per 4 in at full rate. The FLUSH beat costs one extra cycle with f_ready_out=0.
- Backpressure: while b_valid_out && !b_ready_in, b_data_out and b_data_last are held stable and f_ready_out=0.
- Reset (any time, including mid-frame): state S0, res=0, b_valid_out=0, b_data_out=0, b_data_last=0. The partial frame is dropped.
- Back-to-back frames: a new frame may be accepted in the cycle after FLUSH loads, or directly after S3 last. No bubbles otherwise.
- Input in S0 does not need a free output slot, but is gated identically for simplicity.

Optional Feature:
Macro IDMA_RGBA2RGB_STRB_EN.
- Defined: adds output port b_strb [31:0], a registered byte strobe loaded with the data. It is all-ones for normal beats. For FLUSH beats it is 32'h00FFFFFF (192b), 32'h0000FFFF (128b) or 32'h000000FF (64b). Reset value 0.
- Not defined: no port, no logic.

Test Plan:
1. 4 beats, pixel k = {8'hFF, 24'(k)}, k=0..31, b_ready_in=1. Expect 3 beats:
   - beat0 [24i+:24] = i for i=0..9, with [240+:16] = 16'h000A.
   - beat2 [232+:24] = 24'h00001F.
   - b_data_last=0, or 1 on beat2 if f_data_last was set on input 3.
   - No alpha bytes FF anywhere.
2. Same stream with b_ready_in toggling 1-0 each cycle. Expect identical output sequence, outputs stable while stalled, and no input accepted while b_valid_out && !b_ready_in.
3. Single beat with f_data_last, pixels 24'h111111..24'h888888. Expect one FLUSH beat: [191:0] = packed pixels, [255:192] = 0, b_data_last=1, b_strb=32'h00FFFFFF.
4. 3-beat frame, last on beat 3. Expect 3 output beats: 2 normal, then FLUSH with 64 valid bits, b_data_last=1 only on the third. f_ready_out=0 for one cycle during FLUSH.
5. Two 4-beat frames back-to-back, last on beat 4 of each. Expect 6 output beats, b_data_last on beats 3 and 6, no FLUSH, no idle cycles.
6. Assert rst after 2 accepted beats of a frame. Expect b_valid_out=0 immediately and no stale residual. A following 4-beat frame produces exactly the case-1 result.
